// File: rtl/rate_mult_pkg.sv
// Shared types and helpers for the rate-multiplier decoder.
package rate_mult_pkg;

    localparam int RMD_DEFAULT_WIDTH = 16;

    typedef enum logic {
        IDLE    = 1'b0,
        MEASURE = 1'b1
    } rmd_state_t;

    // Window length in enable strobes for a generator of 'width' stages.
    function automatic longint unsigned rmd_window_len(input int unsigned width);
        return 64'd1 << width;
    endfunction

endpackage

// File: rtl/rmd_window_counter.sv
// WIDTH-bit enable-qualified window counter with terminal-count flag.
module rmd_window_counter
    import rate_mult_pkg::*;
#(
    parameter int WIDTH = RMD_DEFAULT_WIDTH
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_clr,
    input  logic i_en,
    output logic o_tc
);

    localparam longint unsigned LAST = rmd_window_len(WIDTH) - 64'd1;
    localparam logic [WIDTH-1:0] TC_VAL = LAST[WIDTH-1:0];

    logic [WIDTH-1:0] r_cnt;

    // Wraps naturally at the terminal count, so back-to-back windows need no clear.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_tc = (r_cnt == TC_VAL);

endmodule

// File: rtl/rate_mult_decoder.sv
// Recovers the rate word of a binary rate multiplier by counting pulses over 2^WIDTH strobes.
// Optional LOCK output enabled by defining RATE_MULT_DECODER_LOCK_EN.
module rate_mult_decoder
    import rate_mult_pkg::*;
#(
    parameter int WIDTH      = RMD_DEFAULT_WIDTH,
    parameter bit OVR_STICKY = 1'b1
) (
    input  logic           i_clk,
    input  logic           i_rst_n,
    input  logic           i_en,
    input  logic           i_pulse,
    input  logic           i_start,
    input  logic           i_cont,
    input  logic           i_ack,
    output logic [WIDTH:0] o_rate,
    output logic           o_valid,
    output logic           o_busy,
    output logic           o_ovr,
    output logic           o_lock
);

    rmd_state_t     r_state;
    rmd_state_t     w_next_state;
    logic           w_measure;
    logic           w_tc;
    logic           w_done;
    logic [WIDTH:0] w_result;
    logic [WIDTH:0] r_pcnt;
    logic [WIDTH:0] r_rate;
    logic           r_valid;
    logic           r_ovr;

    assign w_measure = (r_state == MEASURE);
    assign w_done    = w_measure & i_en & w_tc;
    assign w_result  = r_pcnt + {{WIDTH{1'b0}}, i_pulse};

    rmd_window_counter #(
        .WIDTH (WIDTH)
    ) u_window_counter (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_clr   (~w_measure),
        .i_en    (w_measure & i_en),
        .o_tc    (w_tc)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Completion takes priority over START, which is only honoured in IDLE.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (i_start) w_next_state = MEASURE;
            MEASURE: if (w_done && !i_cont) w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_pcnt <= '0;
        end else if (!w_measure || w_done) begin
            r_pcnt <= '0;
        end else if (i_en && i_pulse) begin
            r_pcnt <= r_pcnt + 1'b1;
        end
    end

    // A fresh result always wins over ACK; OVR only flags an unacknowledged overwrite.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rate  <= '0;
            r_valid <= 1'b0;
            r_ovr   <= 1'b0;
        end else begin
            if (w_done) begin
                r_rate  <= w_result;
                r_valid <= 1'b1;
            end else if (i_ack) begin
                r_valid <= 1'b0;
            end

            if (w_done && r_valid && !i_ack) begin
                r_ovr <= 1'b1;
            end else if (i_ack || !OVR_STICKY) begin
                r_ovr <= 1'b0;
            end
        end
    end

`ifdef RATE_MULT_DECODER_LOCK_EN
    logic [WIDTH:0] r_prev;
    logic           r_lock;

    // A result that also drops back to IDLE reports LOCK=0.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_prev <= '0;
            r_lock <= 1'b0;
        end else if (w_done) begin
            r_prev <= w_result;
            r_lock <= i_cont && (w_result == r_prev);
        end else if (!w_measure) begin
            r_lock <= 1'b0;
        end
    end

    assign o_lock = r_lock;
`else
    assign o_lock = 1'b0;
`endif

    assign o_rate  = r_rate;
    assign o_valid = r_valid;
    assign o_busy  = w_measure;
    assign o_ovr   = r_ovr;

endmodule

// File: doc/rate_mult_decoder.md
Name: rate_mult_decoder

Overview:
Receive-side companion to the 16-stage binary rate multiplier. It measures the pulse density of a rate-multiplier output stream and recovers the programmed rate word. It counts qualified pulses over a window of exactly 2^WIDTH enable strobes. The output pattern repeats every 2^WIDTH strobes and contains exactly C pulses per period, so any contiguous window yields C. No phase alignment with the generator is required.

Parameters:
WIDTH, 16, stage count of the generator; the window is 2^WIDTH enable strobes.
OVR_STICKY, 1, 1 = OVR stays set until ACK; 0 = OVR is a one-cycle pulse.

Ports:
CK  input  1  clock, rising edge
RST_N  input  1  asynchronous active-low reset
EN  input  1  enable strobe; same signal as the generator's count enable (P_0)
PULSE  input  1  rate-multiplier output (Z)
START  input  1  one-cycle request to begin a measurement window
CONT  input  1  1 = restart a new window automatically after each completes
RATE  output  WIDTH+1  recovered rate word (pulse count of last complete window)
VALID  output  1  RATE holds an unacknowledged result
ACK  input  1  consumer has taken RATE; clears VALID
BUSY  output  1  window in progress
OVR  output  1  a result was overwritten while VALID was still set
LOCK  output  1  only with the optional feature; otherwise tied 0

Behaviour:
- Reset (async, RST_N=0): state IDLE; RATE=0, VALID=0, BUSY=0, OVR=0, LOCK=0; internal counters cleared.
- Reset mid-window discards the partial count. No result is produced for that window.
- States:
  - IDLE: START=1 -> MEASURE on the next edge. Window counter wcnt=0, pulse counter pcnt=0. BUSY=1 from that edge.
  - MEASURE, each cycle with EN=1: wcnt+=1. If PULSE=1 also, pcnt+=1. Cycles with EN=0 are ignored entirely, including PULSE.
  - MEASURE, on the EN=1 cycle where wcnt == 2^WIDTH-1 (wrap): next edge loads RATE=pcnt+PULSE and sets VALID=1.
    - Then goes to MEASURE with both counters cleared if CONT=1, else to IDLE with BUSY=0.
- Result latency: RATE/VALID update one cycle after the final qualifying EN strobe.
- wcnt is WIDTH bits and wraps naturally. pcnt is WIDTH+1 bits, so the all-ones rate 2^WIDTH (PULSE always 1) is representable. pcnt never saturates.
- START while BUSY is ignored. START and window completion in the same cycle: completion wins; START is ignored.
- ACK=1 clears VALID on the next edge. ACK while VALID=0 has no effect.
- ACK on the same cycle as a new result: the new result wins. VALID stays 1 and OVR does not assert.
- Result arrives while VALID=1 and ACK=0: RATE is overwritten and OVR=1. OVR is cleared by ACK when OVR_STICKY=1; otherwise it lasts one cycle.
- CONT deasserted mid-window: the current window finishes, then the block goes to IDLE.

Optional Feature:
- Macro RATE_MULT_DECODER_LOCK_EN.
- Defined: a WIDTH+1 register holds the previous result. On each new result, LOCK=1 if the new RATE equals the previous one, else LOCK=0. LOCK clears on reset and on entry to IDLE.
- Not defined: no previous-result register; LOCK is constant 0.

Decomposition:
- Shared package rate_mult_pkg holds:
  - state enum rmd_state_t {IDLE, MEASURE};
  - localparam RMD_DEFAULT_WIDTH=16;
  - the function computing the window length 2^WIDTH.
- One natural sub-module: rmd_window_counter, the WIDTH-bit EN-qualified counter with a terminal-count flag. The FSM, pulse counter and result register stay in the top level.

Test Plan:
- WIDTH=4, EN=1 every cycle, PULSE driven by a model rate multiplier with C=0b01011 (11), START once -> after 16 EN cycles (plus 1), RATE=11, VALID=1, BUSY=0.
- WIDTH=4, EN strobed every 3rd cycle, PULSE high on every cycle -> RATE=16 after 48 cycles; non-EN pulses are not counted.
- WIDTH=4, CONT=1, C=5, no ACK -> first result RATE=5 with VALID; the second window raises OVR=1 with RATE=5. ACK then clears VALID and OVR.
- WIDTH=4, START mid-window, then RST_N low for 1 cycle at window count 7 -> all outputs 0 and IDLE. The next START gives a correct full-window count.
- WIDTH=4, ACK asserted exactly on the completion cycle -> VALID stays 1 and OVR stays 0.
- With RATE_MULT_DECODER_LOCK_EN, CONT=1, C=9 for two windows, then C=3 -> LOCK 0, 1, then 0.
